// File: rtl/nios2_mul_result_combine.sv
// Reduces the three 16x16 partial products to the low product word and
// queues results toward writeback under credit-based flow control.
module nios2_mul_result_combine #(
  parameter int TAG_W = 5,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [31:0]      M_mul_cell_p1,
  input  logic [31:0]      M_mul_cell_p2,
  input  logic [31:0]      M_mul_cell_p3,
  input  logic             M_mul_valid,
  input  logic [TAG_W-1:0] M_mul_tag,
  output logic             M_mul_ready,
  output logic [31:0]      A_mul_result,
  output logic [TAG_W-1:0] A_mul_tag,
  output logic             A_mul_valid,
  input  logic             A_mul_ready,
  output logic             mul_overflow_err
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = PW + 1;

  logic             s1_valid;
  logic [15:0]      s1_lo;
  logic [15:0]      s1_hi;
  logic [TAG_W-1:0] s1_tag;

  logic             s2_valid;
  logic [31:0]      s2_data;
  logic [TAG_W-1:0] s2_tag;

  logic [31:0]      mem_data [DEPTH];
  logic [TAG_W-1:0] mem_tag  [DEPTH];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic [CW-1:0]    count;

  logic             accept;
  logic [15:0]      hi_sum;
  logic             push;
  logic             pop;
  logic             full;
  logic             wr_en;
  logic [CW:0]      used;

  assign accept = M_mul_valid & M_mul_ready;
  assign hi_sum = M_mul_cell_p1[31:16]
                + M_mul_cell_p2[15:0]
                + M_mul_cell_p3[15:0];

  // Credits count everything accepted but not yet popped.
  assign used = {1'b0, count}
              + (CW+1)'(s1_valid)
              + (CW+1)'(s2_valid);
  assign M_mul_ready = used < (CW+1)'(DEPTH);

  assign full        = count == CW'(DEPTH);
  assign A_mul_valid = count != '0;
  assign push        = s2_valid;
  assign pop         = A_mul_valid & A_mul_ready;
  assign wr_en       = push & (~full | pop);

  assign A_mul_result = A_mul_valid ? mem_data[rd_ptr] : '0;
  assign A_mul_tag    = A_mul_valid ? mem_tag[rd_ptr]  : '0;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s1_valid         <= 1'b0;
      s2_valid         <= 1'b0;
      wr_ptr           <= '0;
      rd_ptr           <= '0;
      count            <= '0;
      mul_overflow_err <= 1'b0;
    end else begin
      s1_valid <= accept;
      s2_valid <= s1_valid;
      if (wr_en)
        wr_ptr <= wr_ptr + 1'b1;
      if (pop)
        rd_ptr <= rd_ptr + 1'b1;
      if (wr_en & ~pop)
        count <= count + 1'b1;
      else if (~wr_en & pop)
        count <= count - 1'b1;
      if (push & full & ~pop)
        mul_overflow_err <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (accept) begin
      s1_lo  <= M_mul_cell_p1[15:0];
      s1_hi  <= hi_sum;
      s1_tag <= M_mul_tag;
    end
    s2_data <= {s1_hi, s1_lo};
    s2_tag  <= s1_tag;
    if (wr_en) begin
      mem_data[wr_ptr] <= s2_data;
      mem_tag[wr_ptr]  <= s2_tag;
    end
  end

endmodule
